// File: rtl/alu_rs_if.sv
// ============================================================================
//  Module      : alu_rs_if
//  Description : Issue, CDB snoop and ALU dispatch bundle for the ALU
//                reservation station.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface alu_rs_if #(
    parameter int ROB_W = 4,
    parameter int OP_W  = 6
);
    logic             rdy;
    logic             clear;

    logic             issue_sgn;
    logic [OP_W-1:0]  issue_opcode;
    logic [ROB_W-1:0] issue_rob;
    logic             issue_qj_v;
    logic [ROB_W-1:0] issue_qj;
    logic [31:0]      issue_vj;
    logic             issue_qk_v;
    logic [ROB_W-1:0] issue_qk;
    logic [31:0]      issue_vk;
    logic             full;

    logic             cdb_alu_sgn;
    logic [ROB_W-1:0] cdb_alu_rob;
    logic [31:0]      cdb_alu_res;
    logic             cdb_lsb_sgn;
    logic [ROB_W-1:0] cdb_lsb_rob;
    logic [31:0]      cdb_lsb_res;

    logic             alu_sgn;
    logic [OP_W-1:0]  alu_opcode;
    logic [ROB_W-1:0] alu_rob;
    logic [31:0]      alu_lhs;
    logic [31:0]      alu_rhs;

    modport master (
        output rdy, clear,
        output issue_sgn, issue_opcode, issue_rob,
        output issue_qj_v, issue_qj, issue_vj, issue_qk_v, issue_qk, issue_vk,
        output cdb_alu_sgn, cdb_alu_rob, cdb_alu_res,
        output cdb_lsb_sgn, cdb_lsb_rob, cdb_lsb_res,
        input  full,
        input  alu_sgn, alu_opcode, alu_rob, alu_lhs, alu_rhs
    );

    modport slave (
        input  rdy, clear,
        input  issue_sgn, issue_opcode, issue_rob,
        input  issue_qj_v, issue_qj, issue_vj, issue_qk_v, issue_qk, issue_vk,
        input  cdb_alu_sgn, cdb_alu_rob, cdb_alu_res,
        input  cdb_lsb_sgn, cdb_lsb_rob, cdb_lsb_res,
        output full,
        output alu_sgn, alu_opcode, alu_rob, alu_lhs, alu_rhs
    );
endinterface

`default_nettype wire

// File: rtl/alu_rs.sv
// ============================================================================
//  Module      : alu_rs
//  Description : Reservation station for the integer ALU: buffers renamed ops,
//                snoops both CDBs and dispatches the lowest ready entry.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_rs #(
    parameter int RS_SIZE = 16,
    parameter int ROB_W   = 4,
    parameter int OP_W    = 6
) (
    input  wire logic clk,
    input  wire logic rst,
    alu_rs_if.slave   bus
);
    localparam int c_IDX_W = $clog2(RS_SIZE);

    logic [RS_SIZE-1:0] r_busy;
    logic [RS_SIZE-1:0] r_qj_v;
    logic [RS_SIZE-1:0] r_qk_v;
    logic [OP_W-1:0]    r_opcode [RS_SIZE];
    logic [ROB_W-1:0]   r_rob    [RS_SIZE];
    logic [ROB_W-1:0]   r_qj     [RS_SIZE];
    logic [ROB_W-1:0]   r_qk     [RS_SIZE];
    logic [31:0]        r_vj     [RS_SIZE];
    logic [31:0]        r_vk     [RS_SIZE];

    logic               r_full;
    logic               r_alu_sgn;
    logic [OP_W-1:0]    r_alu_opcode;
    logic [ROB_W-1:0]   r_alu_rob;
    logic [31:0]        r_alu_lhs;
    logic [31:0]        r_alu_rhs;

    logic [RS_SIZE-1:0] w_ready;
    logic               w_disp_found;
    logic [c_IDX_W-1:0] w_disp_idx;
    logic [c_IDX_W-1:0] w_free_idx;
    logic               w_issue_ok;
    logic [RS_SIZE-1:0] w_busy_nxt;
    logic               w_full_nxt;
    logic               w_iss_qj_v;
    logic               w_iss_qk_v;
    logic [31:0]        w_iss_vj;
    logic [31:0]        w_iss_vk;

    // Selection and occupancy look only at registered state, so an entry woken
    // or freed on this edge is not visible until the next cycle.
    always_comb begin
        w_ready    = '0;
        w_disp_idx = '0;
        w_free_idx = '0;
        for (int i = 0; i < RS_SIZE; i++) begin
            w_ready[i] = r_busy[i] & ~r_qj_v[i] & ~r_qk_v[i];
        end
        for (int i = RS_SIZE - 1; i >= 0; i--) begin
            if (w_ready[i]) w_disp_idx = i[c_IDX_W-1:0];
            if (!r_busy[i]) w_free_idx = i[c_IDX_W-1:0];
        end
        w_disp_found = |w_ready;
        w_issue_ok   = bus.issue_sgn & ~r_full;

        w_busy_nxt = r_busy;
        if (w_disp_found) w_busy_nxt[w_disp_idx] = 1'b0;
        if (w_issue_ok)   w_busy_nxt[w_free_idx] = 1'b1;
        w_full_nxt = &w_busy_nxt;
    end

    // Same-cycle CDB forwarding into the operands of the op being issued.
    always_comb begin
        w_iss_qj_v = bus.issue_qj_v;
        w_iss_vj   = bus.issue_vj;
        w_iss_qk_v = bus.issue_qk_v;
        w_iss_vk   = bus.issue_vk;
        if (bus.issue_qj_v && bus.cdb_alu_sgn && bus.cdb_alu_rob == bus.issue_qj) begin
            w_iss_qj_v = 1'b0;
            w_iss_vj   = bus.cdb_alu_res;
        end else if (bus.issue_qj_v && bus.cdb_lsb_sgn && bus.cdb_lsb_rob == bus.issue_qj) begin
            w_iss_qj_v = 1'b0;
            w_iss_vj   = bus.cdb_lsb_res;
        end
        if (bus.issue_qk_v && bus.cdb_alu_sgn && bus.cdb_alu_rob == bus.issue_qk) begin
            w_iss_qk_v = 1'b0;
            w_iss_vk   = bus.cdb_alu_res;
        end else if (bus.issue_qk_v && bus.cdb_lsb_sgn && bus.cdb_lsb_rob == bus.issue_qk) begin
            w_iss_qk_v = 1'b0;
            w_iss_vk   = bus.cdb_lsb_res;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy       <= '0;
            r_qj_v       <= '0;
            r_qk_v       <= '0;
            r_full       <= 1'b0;
            r_alu_sgn    <= 1'b0;
            r_alu_opcode <= '0;
            r_alu_rob    <= '0;
            r_alu_lhs    <= '0;
            r_alu_rhs    <= '0;
            for (int i = 0; i < RS_SIZE; i++) begin
                r_opcode[i] <= '0;
                r_rob[i]    <= '0;
                r_qj[i]     <= '0;
                r_qk[i]     <= '0;
                r_vj[i]     <= '0;
                r_vk[i]     <= '0;
            end
        end else if (bus.rdy) begin
            if (bus.clear) begin
                r_busy    <= '0;
                r_full    <= 1'b0;
                r_alu_sgn <= 1'b0;
            end else begin
                // Wakeup: the ALU CDB takes precedence when both carry the same tag.
                for (int i = 0; i < RS_SIZE; i++) begin
                    if (r_busy[i] && r_qj_v[i]) begin
                        if (bus.cdb_alu_sgn && bus.cdb_alu_rob == r_qj[i]) begin
                            r_qj_v[i] <= 1'b0;
                            r_vj[i]   <= bus.cdb_alu_res;
                        end else if (bus.cdb_lsb_sgn && bus.cdb_lsb_rob == r_qj[i]) begin
                            r_qj_v[i] <= 1'b0;
                            r_vj[i]   <= bus.cdb_lsb_res;
                        end
                    end
                    if (r_busy[i] && r_qk_v[i]) begin
                        if (bus.cdb_alu_sgn && bus.cdb_alu_rob == r_qk[i]) begin
                            r_qk_v[i] <= 1'b0;
                            r_vk[i]   <= bus.cdb_alu_res;
                        end else if (bus.cdb_lsb_sgn && bus.cdb_lsb_rob == r_qk[i]) begin
                            r_qk_v[i] <= 1'b0;
                            r_vk[i]   <= bus.cdb_lsb_res;
                        end
                    end
                end

                r_alu_sgn <= w_disp_found;
                if (w_disp_found) begin
                    r_alu_opcode <= r_opcode[w_disp_idx];
                    r_alu_rob    <= r_rob[w_disp_idx];
                    r_alu_lhs    <= r_vj[w_disp_idx];
                    r_alu_rhs    <= r_vk[w_disp_idx];
                end

                if (w_issue_ok) begin
                    r_opcode[w_free_idx] <= bus.issue_opcode;
                    r_rob[w_free_idx]    <= bus.issue_rob;
                    r_qj[w_free_idx]     <= bus.issue_qj;
                    r_qk[w_free_idx]     <= bus.issue_qk;
                    r_qj_v[w_free_idx]   <= w_iss_qj_v;
                    r_qk_v[w_free_idx]   <= w_iss_qk_v;
                    r_vj[w_free_idx]     <= w_iss_vj;
                    r_vk[w_free_idx]     <= w_iss_vk;
                end

                r_busy <= w_busy_nxt;
                r_full <= w_full_nxt;
            end
        end
    end

    assign bus.full       = r_full;
    assign bus.alu_sgn    = r_alu_sgn;
    assign bus.alu_opcode = r_alu_opcode;
    assign bus.alu_rob    = r_alu_rob;
    assign bus.alu_lhs    = r_alu_lhs;
    assign bus.alu_rhs    = r_alu_rhs;

endmodule

`default_nettype wire

// File: tb/tb_alu_rs.sv
// ============================================================================
//  Module      : tb_alu_rs
//  Description : Directed self-checking bench for the ALU reservation station.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_rs;
    localparam int c_RS    = 16;
    localparam int c_ROB_W = 4;
    localparam int c_OP_W  = 6;
    localparam logic [5:0] c_ADD = 6'd1;
    localparam logic [5:0] c_SUB = 6'd2;
    localparam logic [5:0] c_OR  = 6'd3;

    logic r_clk = 1'b0;
    logic r_rst;
    int   n_vec = 0;
    int   n_err = 0;

    alu_rs_if #(.ROB_W(c_ROB_W), .OP_W(c_OP_W)) bus ();

    alu_rs #(.RS_SIZE(c_RS), .ROB_W(c_ROB_W), .OP_W(c_OP_W)) u_dut (
        .clk (r_clk),
        .rst (r_rst),
        .bus (bus.slave)
    );

    always #5 r_clk = ~r_clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge r_clk);
        #1;
    endtask

    task automatic idle_in();
        bus.issue_sgn   = 1'b0;
        bus.cdb_alu_sgn = 1'b0;
        bus.cdb_lsb_sgn = 1'b0;
        bus.clear       = 1'b0;
    endtask

    task automatic issue(input logic [5:0] op, input logic [3:0] rob,
                         input logic qjv, input logic [3:0] qj, input logic [31:0] vj,
                         input logic qkv, input logic [3:0] qk, input logic [31:0] vk);
        bus.issue_sgn    = 1'b1;
        bus.issue_opcode = op;
        bus.issue_rob    = rob;
        bus.issue_qj_v   = qjv;
        bus.issue_qj     = qj;
        bus.issue_vj     = vj;
        bus.issue_qk_v   = qkv;
        bus.issue_qk     = qk;
        bus.issue_vk     = vk;
    endtask

    task automatic expect_disp(input string tag, input logic [3:0] rob,
                               input logic [31:0] lhs, input logic [31:0] rhs);
        chk({tag, ".sgn"}, 32'(bus.alu_sgn), 32'd1);
        chk({tag, ".rob"}, 32'(bus.alu_rob), 32'(rob));
        chk({tag, ".lhs"}, bus.alu_lhs, lhs);
        chk({tag, ".rhs"}, bus.alu_rhs, rhs);
    endtask

    initial begin
        r_rst           = 1'b1;
        bus.rdy         = 1'b1;
        idle_in();
        issue(6'd0, 4'd0, 1'b0, 4'd0, 32'd0, 1'b0, 4'd0, 32'd0);
        bus.issue_sgn   = 1'b0;
        bus.cdb_alu_rob = '0;
        bus.cdb_alu_res = '0;
        bus.cdb_lsb_rob = '0;
        bus.cdb_lsb_res = '0;
        tick();
        tick();
        chk("rst.sgn",  32'(bus.alu_sgn),    32'd0);
        chk("rst.full", 32'(bus.full),       32'd0);
        chk("rst.op",   32'(bus.alu_opcode), 32'd0);
        chk("rst.lhs",  bus.alu_lhs,         32'd0);
        r_rst = 1'b0;

        // Ready op dispatches one cycle after it lands
        issue(c_ADD, 4'd3, 1'b0, 4'd0, 32'd5, 1'b0, 4'd0, 32'd7);
        tick();
        idle_in();
        chk("add.lat", 32'(bus.alu_sgn), 32'd0);
        tick();
        expect_disp("add", 4'd3, 32'd5, 32'd7);
        chk("add.op", 32'(bus.alu_opcode), 32'(c_ADD));
        tick();
        chk("add.once", 32'(bus.alu_sgn), 32'd0);
        chk("add.hold", bus.alu_lhs, 32'd5);

        // Wakeup from the load/store CDB
        issue(c_SUB, 4'd2, 1'b1, 4'd1, 32'd0, 1'b0, 4'd0, 32'd3);
        tick();
        idle_in();
        bus.cdb_lsb_sgn = 1'b1; bus.cdb_lsb_rob = 4'd1; bus.cdb_lsb_res = 32'h10;
        tick();
        idle_in();
        chk("sub.wait", 32'(bus.alu_sgn), 32'd0);
        tick();
        expect_disp("sub", 4'd2, 32'h10, 32'd3);
        chk("sub.op", 32'(bus.alu_opcode), 32'(c_SUB));

        // Same-cycle CDB forwarding at issue
        issue(c_ADD, 4'd5, 1'b0, 4'd0, 32'd1, 1'b1, 4'd4, 32'd0);
        bus.cdb_alu_sgn = 1'b1; bus.cdb_alu_rob = 4'd4; bus.cdb_alu_res = 32'd9;
        tick();
        idle_in();
        tick();
        expect_disp("fwd", 4'd5, 32'd1, 32'd9);
        tick();

        // rdy low freezes a stored ready op
        issue(c_OR, 4'd6, 1'b0, 4'd0, 32'd11, 1'b0, 4'd0, 32'd12);
        tick();
        idle_in();
        bus.rdy = 1'b0;
        tick();
        chk("frz.sgn", 32'(bus.alu_sgn), 32'd0);
        bus.rdy = 1'b1;
        tick();
        expect_disp("frz", 4'd6, 32'd11, 32'd12);
        tick();

        // Fill: entry 0 waits on tag 9, the rest on tag 8
        for (int i = 0; i < c_RS; i++) begin
            issue(c_OR, 4'(i), 1'b1, (i == 0) ? 4'd9 : 4'd8, 32'd0, 1'b0, 4'd0, 32'(i));
            tick();
            if (i == c_RS - 2) chk("fill.notfull", 32'(bus.full), 32'd0);
        end
        chk("fill.full", 32'(bus.full), 32'd1);
        issue(c_ADD, 4'd14, 1'b0, 4'd0, 32'hDEAD, 1'b0, 4'd0, 32'd0);
        tick();
        idle_in();
        chk("drop.full", 32'(bus.full), 32'd1);
        chk("drop.sgn",  32'(bus.alu_sgn), 32'd0);
        bus.cdb_alu_sgn = 1'b1; bus.cdb_alu_rob = 4'd9; bus.cdb_alu_res = 32'h55;
        tick();
        idle_in();
        chk("wake.full", 32'(bus.full), 32'd1);
        tick();
        expect_disp("e0", 4'd0, 32'h55, 32'd0);
        chk("free.full", 32'(bus.full), 32'd0);

        // Flush with 15 busy and a simultaneous issue
        bus.clear = 1'b1;
        issue(c_ADD, 4'd10, 1'b0, 4'd0, 32'd1, 1'b0, 4'd0, 32'd2);
        tick();
        idle_in();
        chk("clr.sgn",  32'(bus.alu_sgn), 32'd0);
        chk("clr.full", 32'(bus.full),    32'd0);
        tick();
        chk("clr.nodisp", 32'(bus.alu_sgn), 32'd0);

        // Entries 0 and 5 wait on tag 6, entries 1..4 on tag 7
        for (int i = 0; i < 6; i++) begin
            issue(c_ADD, 4'(i), 1'b1, (i == 0 || i == 5) ? 4'd6 : 4'd7, 32'd0,
                  1'b0, 4'd0, 32'(i + 100));
            tick();
        end
        idle_in();
        bus.cdb_alu_sgn = 1'b1; bus.cdb_alu_rob = 4'd6; bus.cdb_alu_res = 32'hA0;
        tick();
        idle_in();
        tick();
        expect_disp("ord0", 4'd0, 32'hA0, 32'd100);
        tick();
        expect_disp("ord5", 4'd5, 32'hA0, 32'd105);
        tick();
        chk("ord.idle", 32'(bus.alu_sgn), 32'd0);

        // Both CDBs carry tag 7: ALU value wins
        bus.cdb_alu_sgn = 1'b1; bus.cdb_alu_rob = 4'd7; bus.cdb_alu_res = 32'h11;
        bus.cdb_lsb_sgn = 1'b1; bus.cdb_lsb_rob = 4'd7; bus.cdb_lsb_res = 32'h22;
        tick();
        idle_in();
        for (int i = 1; i <= 4; i++) begin
            tick();
            expect_disp($sformatf("pri%0d", i), 4'(i), 32'h11, 32'(i + 100));
        end
        tick();
        chk("end.idle", 32'(bus.alu_sgn), 32'd0);
        chk("end.full", 32'(bus.full),    32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

`default_nettype wire
